// File: rtl/dap_bit_shifter_if.sv
// Command/response handshake between the SWD/JTAG sequencer and the bit shifter.
// The sequencer is the master; the shifter engine is the slave.
interface dap_bit_shifter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_dir;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_dir, cmd_len, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_len, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dap_bit_shifter.sv
// Serial bit engine: shifts up to DATA_WIDTH bits LSB first, driving the pin on SCLK
// strobes for writes and sampling the synchronized pin on delayed strobes for reads.
module dap_bit_shifter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              sclk_pulse_i,
    input  logic              sclk_delay_pulse_i,
    input  logic              abort_i,
    input  logic              dio_in_i,
    dap_bit_shifter_if.slave  bus_if,
    output logic              busy_o,
    output logic              dio_out_o,
    output logic              dio_oe_o
);

    typedef enum logic [1:0] {StIdle, StArm, StShift, StDone} state_e;

    localparam logic [LEN_WIDTH:0]   CntOne = (LEN_WIDTH+1)'(1);
    localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(DATA_WIDTH - 1);

    state_e                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  sh_q, sh_d;
    logic                   out_q, out_d;
    logic                   oe_q, oe_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dio_sync;
    logic [LEN_WIDTH:0]     len_ext;

    assign dio_sync = sync_q[SYNC_STAGES-1];
    assign len_ext  = {1'b0, len_q};

    // One register serves both directions: writes shift data out of bit 0,
    // reads shift samples in at the top, so both are right shifts.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        out_d   = out_q;
        oe_d    = oe_q;
        unique case (state_q)
            StIdle: begin
                if (bus_if.cmd_valid) begin
                    dir_d   = bus_if.cmd_dir;
                    len_d   = bus_if.cmd_len;
                    sh_d    = bus_if.cmd_wdata;
                    cnt_d   = '0;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (sclk_pulse_i) begin
                    state_d = StShift;
                    if (dir_q) begin
                        oe_d  = 1'b1;
                        out_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                        cnt_d = CntOne;
                    end else begin
                        oe_d = 1'b0;
                        // Zero-delay generator: the arming pulse is also sample 0.
                        if (sclk_delay_pulse_i) begin
                            sh_d  = {dio_sync, sh_q[DATA_WIDTH-1:1]};
                            cnt_d = CntOne;
                            if (len_q == '0) state_d = StDone;
                        end
                    end
                end
            end
            StShift: begin
                if (dir_q) begin
                    if (sclk_pulse_i) begin
                        // Extra pulse after the last bit holds it for a full SCLK period.
                        if (cnt_q == len_ext + CntOne) begin
                            state_d = StDone;
                        end else begin
                            out_d = sh_q[0];
                            sh_d  = sh_q >> 1;
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                end else if (sclk_delay_pulse_i) begin
                    sh_d  = {dio_sync, sh_q[DATA_WIDTH-1:1]};
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == len_ext) state_d = StDone;
                end
            end
            StDone: begin
                if (bus_if.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            oe_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            out_q   <= 1'b0;
            oe_q    <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            sync_q[0] <= dio_in_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus_if.cmd_ready = (state_q == StIdle);
    assign bus_if.rsp_valid = (state_q == StDone);
    assign bus_if.rsp_rdata = ((state_q == StDone) && !dir_q) ? (sh_q >> (MaxLen - len_q)) : '0;
    assign busy_o           = (state_q != StIdle);
    assign dio_out_o        = out_q;
    assign dio_oe_o         = oe_q;

endmodule

// File: tb/tb_dap_bit_shifter.sv
// Directed bench for dap_bit_shifter: table of commands with hand-computed results,
// plus stall, abort and mid-transfer reset sequences, against a modelled baud generator.
module tb_dap_bit_shifter;

    localparam int PER = 8;

    logic clk = 1'b0;
    logic resetn;
    logic sclk_pulse, sclk_delay_pulse, abort, dio_in;
    logic busy, dio_out, dio_oe;

    dap_bit_shifter_if #(.DATA_WIDTH(32), .LEN_WIDTH(5)) bus ();

    dap_bit_shifter #(.DATA_WIDTH(32), .LEN_WIDTH(5), .SYNC_STAGES(2)) dut (
        .clk_i              (clk),
        .resetn_i           (resetn),
        .sclk_pulse_i       (sclk_pulse),
        .sclk_delay_pulse_i (sclk_delay_pulse),
        .abort_i            (abort),
        .dio_in_i           (dio_in),
        .bus_if             (bus),
        .busy_o             (busy),
        .dio_out_o          (dio_out),
        .dio_oe_o           (dio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dir;
        logic [4:0]  len;
        logic [31:0] wdata;
        logic [31:0] pin;
        int          dly;
        int          stall;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];
    int checks = 0;
    int errors = 0;

    // Baud generator and pin model; pin bit i changes 3 clocks before sample i.
    logic        gen_en = 1'b0;
    int          gen_dly = 3;
    logic [31:0] pin_word = '0;
    int          ph, pin_idx, pin_ph;

    initial begin
        sclk_pulse = 1'b0;
        sclk_delay_pulse = 1'b0;
        dio_in = 1'b0;
        ph = 0;
        pin_idx = 0;
        forever begin
            @(negedge clk);
            pin_ph = (gen_dly + PER - 3) % PER;
            if (!gen_en) begin
                sclk_pulse = 1'b0;
                sclk_delay_pulse = 1'b0;
                pin_idx = 0;
                ph = (gen_dly >= 3) ? 0 : pin_ph;
            end else begin
                sclk_pulse = (ph == 0);
                sclk_delay_pulse = (ph == gen_dly);
                if (ph == pin_ph) begin
                    dio_in = pin_word[pin_idx % 32];
                    pin_idx++;
                end
                ph = (ph + 1) % PER;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_outs"}, {26'd0, bus.cmd_ready, bus.rsp_valid, busy, dio_out, dio_oe},
            32'b10000);
        chk({name, "_rdata"}, bus.rsp_rdata, 32'h0);
    endtask

    task automatic start_cmd(input vec_t v);
        @(posedge clk); #1;
        chk("idle_ready", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = v.dir;
        bus.cmd_len   = v.len;
        bus.cmd_wdata = v.wdata;
        gen_dly  = v.dly;
        pin_word = v.pin;
        @(posedge clk); #1;
        chk("accept_ready_busy", {30'd0, bus.cmd_ready, busy}, 32'b01);
        bus.cmd_valid = 1'b0;
        gen_en = 1'b1;
    endtask

    task automatic finish_cmd(input vec_t v);
        int  np = 0;
        bit  done = 0;
        logic p;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(posedge clk);
            p = sclk_pulse;
            #1;
            if (v.dir && p) begin
                np++;
                if (np <= v.len + 1) begin
                    chk("wbit", dio_out, v.wdata[np-1]);
                    chk("woe", dio_oe, 1'b1);
                end
            end
            if (bus.rsp_valid) done = 1;
        end
        if (!done) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            if (v.dir) chk("wpulses", np, v.len + 2);
            chk("rdata", bus.rsp_rdata, v.exp);
            chk("oe_done", dio_oe, v.dir);
        end
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_rdata", bus.rsp_rdata, v.exp);
            chk("stall_ready", bus.cmd_ready, 1'b0);
        end
        gen_en = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b01);
        chk("oe_idle", dio_oe, v.dir);
    endtask

    task automatic run_vec(input vec_t v);
        start_cmd(v);
        finish_cmd(v);
    endtask

    // Wait for n strobes of the running command; returns 0 if the bound expires.
    task automatic wait_pulses(input int n, output bit ok);
        int np = 0;
        ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(posedge clk);
            if (sclk_pulse) np++;
            #1;
            if (np >= n) ok = 1;
        end
        if (!ok) chk("pulse_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        vec_t ab;

        //        dir   len    wdata         pin           dly stall exp
        vecs[0] = '{1'b1, 5'd7,  32'h000000A5, 32'h0,        3, 0,  32'h0};
        vecs[1] = '{1'b0, 5'd31, 32'h0,        32'hDEADBEEF, 3, 0,  32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd2,  32'h0,        32'hFFFFFFFB, 3, 0,  32'h3};
        vecs[3] = '{1'b0, 5'd2,  32'hFFFFFFFF, 32'hFFFFFFFB, 0, 0,  32'h3};
        vecs[4] = '{1'b0, 5'd2,  32'h0,        32'h00000003, 3, 10, 32'h3};
        vecs[5] = '{1'b1, 5'd0,  32'h00000001, 32'h0,        0, 0,  32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        32'hAAAAAAAB, 0, 0,  32'h1};
        vecs[7] = '{1'b0, 5'd7,  32'h0,        32'h1234565A, 5, 0,  32'h5A};
        vecs[8] = '{1'b1, 5'd31, 32'h80000001, 32'h0,        2, 0,  32'h0};
        ab      = '{1'b1, 5'd15, 32'h0000FFFF, 32'h0,        3, 0,  32'h0};

        resetn = 1'b0;
        abort = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir = 1'b0;
        bus.cmd_len = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("after_reset");

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Abort a write after four bits have gone out.
        start_cmd(ab);
        wait_pulses(4, ok);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_state", {29'd0, dio_oe, bus.rsp_valid, bus.cmd_ready}, 32'b001);
        chk("abort_busy", busy, 1'b0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen |= bus.rsp_valid;
        end
        chk("abort_norsp", seen, 1'b0);
        gen_en = 1'b0;
        run_vec(vecs[0]);

        // Reset in the middle of a read; dio_out is still 1 from the last write bit.
        start_cmd(vecs[1]);
        wait_pulses(5, ok);
        chk("pre_reset_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        gen_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        run_vec(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
